reg_dump_reader: RTL and testbench

- Debug/readout engine for the 8-bit accumulator core's register file; it is the reader side of the register write interface.
- On a start pulse it walks every register address, samples the register file's read port, and streams each word out over a valid/ready interface with its address.
- It snoops the core's register write port so that a buffered word which has not yet been accepted stays coherent with the register file.
- It sits beside the register file in the top level, on the debug/test path.

---
 rtl/reg_dump_reader.sv | 154 +++++++++++++++
 tb/tb_reg_dump_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks every register, streams value+address over valid/ready,
// snooping core writes to keep a stalled beat coherent. Define REG_DUMP_CHECKSUM_EN for a trailing XOR beat.
module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         start,
  input  logic         abort,
  output logic [D-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  input  logic         wr_en,
  input  logic [D-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [W-1:0] dout_data,
  output logic [D-1:0] dout_addr,
  output logic         dout_last,
  output logic         dout_sum,
  output logic         busy,
  output logic         done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, SEND, SUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

  localparam logic [D-1:0] LAST_ADDR = '1;
  localparam logic [D-1:0] ONE       = D'(1);

  state_t       state_reg, state_next;
  logic [D-1:0] ptr_reg;
  logic [W-1:0] buf_reg;
  logic [D-1:0] addr_reg;
  logic         done_reg;
  logic         hs;
  logic         is_last;
  logic         finish;

  assign hs      = dout_valid && dout_ready;
  assign is_last = (ptr_reg == LAST_ADDR);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    case (state_reg)
      IDLE: if (start && !abort) state_next = LOAD;
      LOAD: state_next = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (hs) begin
          if (!is_last) begin
            state_next = LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_next = SUM;
`else
            state_next = IDLE;
            finish     = 1'b1;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (hs) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [W-1:0] acc_reg;

  // Accumulates exactly what was accepted, so a snooped update is reflected.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                        acc_reg <= '0;
    else if (state_reg == IDLE && start) acc_reg <= '0;
    else if (state_reg == SEND && hs)    acc_reg <= acc_reg ^ buf_reg;
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_reg  <= '0;
      buf_reg  <= '0;
      addr_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= finish;
      if (state_reg == IDLE && state_next == LOAD)
        ptr_reg <= '0;
      else if (state_reg == SEND && state_next == LOAD)
        ptr_reg <= ptr_reg + ONE;
      if (state_reg == LOAD) begin
        buf_reg  <= rd_data;
        addr_reg <= ptr_reg;
      end else if (state_reg == SEND && !hs && wr_en && wr_addr == addr_reg) begin
        // Keep the held beat in step with the register file while stalled.
        buf_reg <= wr_data;
      end
    end
  end

  always_comb begin
    rd_addr    = '0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_addr  = '0;
    dout_last  = 1'b0;
    dout_sum   = 1'b0;
    busy       = (state_reg != IDLE);
    done       = done_reg;
    case (state_reg)
      LOAD: rd_addr = ptr_reg;
      SEND: begin
        rd_addr    = ptr_reg;
        dout_valid = 1'b1;
        dout_data  = buf_reg;
        dout_addr  = addr_reg;
`ifndef REG_DUMP_CHECKSUM_EN
        dout_last  = is_last;
`endif
      end
`ifdef REG_DUMP_CHECKSUM_EN
      SUM: begin
        rd_addr    = ptr_reg;
        dout_valid = 1'b1;
        dout_data  = acc_reg;
        dout_sum   = 1'b1;
        dout_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected beats queued at stimulus time, popped by a monitor on handshakes.
module tb_reg_dump_reader;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [D-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic         wr_en = 1'b0;
  logic [D-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] dout_data;
  logic [D-1:0] dout_addr;
  logic         dout_last;
  logic         dout_sum;
  logic         busy;
  logic         done;

  logic         stall_en = 1'b0;
  logic [D-1:0] stall_addr = '0;
  logic [W-1:0] regs [N];

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic         last;
    logic         sum;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           start_cyc = 0;
  int           cyc = 0;
  logic [W-1:0] xsum;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int DUMP_CYCLES = 2 * N + 1;
`else
  localparam int DUMP_CYCLES = 2 * N;
`endif

  reg_dump_reader #(.W(W), .D(D)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_addr(dout_addr), .dout_last(dout_last), .dout_sum(dout_sum),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  assign rd_data    = regs[rd_addr];
  assign dout_ready = !(stall_en && dout_addr == stall_addr);

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  // Monitor: one line per accepted beat, compared against the head of the queue.
  always @(negedge CLK) begin
    beat_t got, e;
    if (RESET_N && dout_valid && dout_ready) begin
      got = '{addr: dout_addr, data: dout_data, last: dout_last, sum: dout_sum};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got addr=%0d data=%h last=%b sum=%b, required none",
                 got.addr, got.data, got.last, got.sum);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got addr=%0d data=%h last=%b sum=%b, required addr=%0d data=%h last=%b sum=%b",
                   got.addr, got.data, got.last, got.sum, e.addr, e.data, e.last, e.sum);
        end else begin
          $display("beat addr=%0d data=%h last=%b sum=%b ok", got.addr, got.data, got.last, got.sum);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic write_reg(input logic [D-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic push(input int a, input logic [W-1:0] d);
    logic last;
`ifdef REG_DUMP_CHECKSUM_EN
    last = 1'b0;
`else
    last = (a == N - 1);
`endif
    exp_q.push_back('{addr: D'(a), data: d, last: last, sum: 1'b0});
    xsum = xsum ^ d;
  endtask

  // Registers are preloaded with 8'h10 + address.
  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(i, 8'h10 + W'(i));
  endtask

  task automatic push_sum();
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back('{addr: '0, data: xsum, last: 1'b1, sum: 1'b1});
`endif
  endtask

  task automatic start_dump();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 200), 32'd0);
    tick(); tick();
  endtask

  task automatic wait_addr(input logic [D-1:0] a, input string name);
    int n = 0;
    while (!(dout_valid && dout_addr == a) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 200), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {16'd0, rd_addr, dout_valid, dout_data, dout_addr, dout_last, dout_sum, busy, done}, 32'd0);
  endtask

  initial begin
    int d0;
    tick(); tick();
    chk_all_zero("reset_outputs");
    RESET_N = 1'b1;
    tick();
    for (int i = 0; i < N; i++) write_reg(D'(i), 8'h10 + W'(i));
    chk("checksum_of_preload", 32'(8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13 ^ 8'h14 ^ 8'h15 ^ 8'h16 ^ 8'h17 ^
                                   8'h18 ^ 8'h19 ^ 8'h1A ^ 8'h1B ^ 8'h1C ^ 8'h1D ^ 8'h1E ^ 8'h1F), 32'h00);

    // Basic dump with a stray start pulse mid-walk.
    xsum = '0; push_range(0, N - 1); push_sum();
    d0 = done_cnt;
    start_dump();
    chk("busy_after_start", 32'(busy), 32'd1);
    tick(); tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle("basic");
    chk("basic_done_once", 32'(done_cnt - d0), 32'd1);
    chk("basic_cycles", 32'(done_cyc - start_cyc), 32'(DUMP_CYCLES));
    chk("basic_busy_low", 32'(busy), 32'd0);

    // Backpressure on addr 3 with snoop writes.
    xsum = '0; push_range(0, 2); push(3, 8'hA5); push_range(4, N - 1); push_sum();
    stall_addr = 4'd3; stall_en = 1'b1;
    start_dump();
    wait_addr(4'd3, "stall3");
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {15'd0, dout_valid, dout_addr, 4'd0, dout_data}, {15'd0, 1'b1, 4'd3, 4'd0, 8'h13});
      tick();
    end
    write_reg(4'd3, 8'hA5);
    chk("snoop_update", {24'd0, dout_data}, 32'h0000_00A5);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A; stall_en = 1'b0;
    tick();
    wr_en = 1'b0;
    tick();
    chk("walk_to_addr4", {dout_valid, 3'd0, dout_addr, dout_data}, {1'b1, 3'd0, 4'd4, 8'h14});
    wait_idle("snoop");
    write_reg(4'd3, 8'h13);

    // Abort at addr 7, then a fresh full dump.
    xsum = '0; push_range(0, 6);
    stall_addr = 4'd7; stall_en = 1'b1;
    d0 = done_cnt;
    start_dump();
    wait_addr(4'd7, "abort7");
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_valid_low", {dout_valid, busy}, 32'd0);
    tick(); tick(); tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    stall_en = 1'b0;
    xsum = '0; push_range(0, N - 1); push_sum();
    start_dump();
    wait_idle("redump");
    chk("redump_done", 32'(done_cnt - d0), 32'd1);

    // Abort and start together in IDLE.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", 32'(busy), 32'd0);

    // Asynchronous reset mid-dump.
    xsum = '0; push_range(0, 4);
    stall_addr = 4'd5; stall_en = 1'b1;
    start_dump();
    wait_addr(4'd5, "reset5");
    #2 RESET_N = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    exp_q.delete();
    stall_en = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("reset_idle", 32'(busy), 32'd0);
    d0 = done_cnt;
    xsum = '0; push_range(0, N - 1); push_sum();
    start_dump();
    wait_idle("post_reset");
    chk("post_reset_done", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
